fact_arbiter: RTL and testbench

Round-robin scheduler sharing the single factorial unit between two requesters (requester 0: GPIO path from `gpI1`; requester 1: CPU memory-mapped path). It latches the winner's operand, issues a one-cycle start to the factorial unit, waits for completion, and returns the result and error flag to the requester that was served. It sits between the requester ports and the factorial unit inside `system`.

---
 rtl/fact_arb_pkg.sv | 24 ++
 rtl/fact_arbiter_if.sv | 34 +++
 rtl/fact_rr_pick.sv | 23 ++
 rtl/fact_arbiter.sv | 175 +++++++++++++++++
 tb/tb_fact_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fact_arb_pkg.sv
// Shared types and defaults for the factorial-unit arbiter.
package fact_arb_pkg;

  localparam int N_W_DEFAULT     = 4;
  localparam int RES_W_DEFAULT   = 32;
  localparam int TIMEOUT_DEFAULT = 64;
  localparam int N_REQ           = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  function automatic logic [N_REQ-1:0] req_onehot(input logic idx);
    if (idx) begin
      return 2'b10;
    end else begin
      return 2'b01;
    end
  endfunction

endpackage

// File: rtl/fact_arbiter_if.sv
// Requester-side and factorial-unit-side signals of the arbiter in one bundle.
interface fact_arbiter_if
  import fact_arb_pkg::*;
#(
  parameter int N_W   = N_W_DEFAULT,
  parameter int RES_W = RES_W_DEFAULT
);

  logic [N_REQ-1:0]     req_i;
  logic [N_REQ*N_W-1:0] n_i;
  logic [N_REQ-1:0]     gnt_o;
  logic [N_REQ-1:0]     done_o;
  logic [RES_W-1:0]     result_o;
  logic                 err_o;
  logic                 fu_go;
  logic [N_W-1:0]       fu_n;
  logic                 fu_done;
  logic                 fu_err;
  logic [RES_W-1:0]     fu_result;
  logic                 fu_abort;

  // Arbiter view.
  modport slave (
    input  req_i, n_i, fu_done, fu_err, fu_result,
    output gnt_o, done_o, result_o, err_o, fu_go, fu_n, fu_abort
  );

  // Requesters plus factorial unit view.
  modport master (
    output req_i, n_i, fu_done, fu_err, fu_result,
    input  gnt_o, done_o, result_o, err_o, fu_go, fu_n, fu_abort
  );

endinterface

// File: rtl/fact_rr_pick.sv
// Combinational two-way round-robin pick: the pointed-to requester wins a tie.
module fact_rr_pick
  import fact_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic             ptr,
  output logic [N_REQ-1:0] win,
  output logic             valid
);

  // One-hot winner selection.
  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = req_onehot(ptr);
      default: win = 2'b00;
    endcase
    valid = |req;
  end

endmodule

// File: rtl/fact_arbiter.sv
// Round-robin arbiter sharing one factorial unit between two requesters.
// Optional watchdog on the factorial unit: define FACT_ARB_TIMEOUT_EN.
module fact_arbiter
  import fact_arb_pkg::*;
#(
  parameter int N_W     = N_W_DEFAULT,
  parameter int RES_W   = RES_W_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  fact_arbiter_if.slave bus
);

  arb_state_e       state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             owner_q, owner_d;
  logic [N_W-1:0]   fu_n_q, fu_n_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             go_q, go_d;
  logic             err_q, err_d;
  logic             abort_q, abort_d;
  logic [RES_W-1:0] result_q, result_d;
  logic [N_REQ-1:0] win_s;
  logic             valid_s;
  logic             expired_s;

  fact_rr_pick u_pick (
    .req   (bus.req_i),
    .ptr   (ptr_q),
    .win   (win_s),
    .valid (valid_s)
  );

`ifdef FACT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Cycles since fu_go; expiry lands fu_abort exactly TIMEOUT cycles after fu_go.
  always_comb begin
    if (state_q == ST_START) begin
      cnt_d = CNT_W'(1);
    end else if (state_q == ST_WAIT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_s = (state_q == ST_WAIT) && (cnt_q == CNT_W'(TIMEOUT - 1));
`else
  localparam int timeout_unused = TIMEOUT;
  assign expired_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; arbitration only happens in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (valid_s) state_d = ST_START;
        else         state_d = ST_IDLE;
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.fu_done || expired_s) state_d = ST_DONE;
        else                          state_d = ST_WAIT;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; pulses are produced one edge ahead so they register.
  always_comb begin
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    fu_n_d   = fu_n_q;
    gnt_d    = 2'b00;
    go_d     = 1'b0;
    done_d   = 2'b00;
    abort_d  = 1'b0;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (valid_s) begin
          owner_d = win_s[1];
          fu_n_d  = win_s[1] ? bus.n_i[2*N_W-1:N_W] : bus.n_i[N_W-1:0];
          gnt_d   = win_s;
          go_d    = 1'b1;
        end else begin
          owner_d = owner_q;
        end
      end
      ST_START: begin
        go_d = 1'b0;
      end
      ST_WAIT: begin
        // A completion on the expiry edge takes precedence over the abort.
        if (bus.fu_done) begin
          result_d = bus.fu_result;
          err_d    = bus.fu_err;
          done_d   = req_onehot(owner_q);
        end else if (expired_s) begin
          result_d = {RES_W{1'b0}};
          err_d    = 1'b1;
          abort_d  = 1'b1;
          done_d   = req_onehot(owner_q);
        end else begin
          done_d = 2'b00;
        end
      end
      ST_DONE: begin
        ptr_d = ~ptr_q;
      end
      default: begin
        ptr_d = ptr_q;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q    <= 1'b0;
      owner_q  <= 1'b0;
      fu_n_q   <= {N_W{1'b0}};
      gnt_q    <= 2'b00;
      go_q     <= 1'b0;
      done_q   <= 2'b00;
      abort_q  <= 1'b0;
      result_q <= {RES_W{1'b0}};
      err_q    <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      fu_n_q   <= fu_n_d;
      gnt_q    <= gnt_d;
      go_q     <= go_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign bus.gnt_o    = gnt_q;
  assign bus.fu_go    = go_q;
  assign bus.fu_n     = fu_n_q;
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;
  assign bus.err_o    = err_q;
  assign bus.fu_abort = abort_q;

endmodule

// File: tb/tb_fact_arbiter.sv
// Self-checking bench for fact_arbiter: directed table, randomized jobs against a
// round-robin reference model, and multi-cycle corner sequences.
module tb_fact_arbiter;

  localparam int N_W     = 4;
  localparam int RES_W   = 32;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fact_arbiter_if #(.N_W(N_W), .RES_W(RES_W)) bus ();

  fact_arbiter #(.N_W(N_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic        m_ptr = 1'b0;
  logic [31:0] last_res = 32'd0;
  logic        last_err = 1'b0;
  logic [3:0]  m_n [2];

  // Behavioural factorial unit: completes stub_lat cycles after seeing fu_go.
  logic        stub_en   = 1'b1;
  int          stub_lat  = 1;
  int          stub_cnt  = 0;
  logic        stub_done = 1'b0;
  logic [31:0] stub_res  = 32'd0;
  logic        stub_err  = 1'b0;
  logic        man_done  = 1'b0;
  logic [31:0] man_res   = 32'd0;

  assign bus.fu_done   = stub_done | man_done;
  assign bus.fu_result = man_done ? man_res : stub_res;
  assign bus.fu_err    = man_done ? 1'b1 : stub_err;

  function automatic logic [31:0] ref_fact(input int n);
    longint p;
    p = 64'd1;
    for (int i = 2; i <= n; i++) p = p * longint'(i);
    return p[31:0];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_cnt  <= 0;
      stub_done <= 1'b0;
    end else begin
      stub_done <= 1'b0;
      if (bus.fu_go && stub_en) begin
        stub_cnt <= stub_lat;
      end else if (stub_cnt == 1) begin
        stub_cnt  <= 0;
        stub_done <= 1'b1;
        stub_res  <= ref_fact(int'(bus.fu_n));
        stub_err  <= (bus.fu_n > 4'd12);
      end else if (stub_cnt > 1) begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One job: raise requests, expect a grant to exp_gnt, then done_o after lat+2 cycles.
  task automatic run_job(input logic [1:0] req, input logic [3:0] n0, input logic [3:0] n1,
                         input logic [1:0] exp_gnt, input logic [31:0] exp_res,
                         input logic exp_err, input int lat, input logic side);
    logic       got;
    logic [3:0] n_win;
    int         t;
    bus.req_i = req;
    bus.n_i   = {n1, n0};
    stub_lat  = lat;
    n_win     = exp_gnt[1] ? n1 : n0;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = (bus.gnt_o != 2'b00);
    end
    check("gnt_seen", 64'(got), 64'd1);
    if (!got) return;
    check("gnt", 64'(bus.gnt_o), 64'(exp_gnt));
    check("fu_go", 64'(bus.fu_go), 64'd1);
    check("fu_n", 64'(bus.fu_n), 64'(n_win));
    bus.req_i = bus.req_i & ~bus.gnt_o;
    if (exp_gnt[1]) bus.n_i[7:4] = ~n1;
    else            bus.n_i[3:0] = ~n0;
    got = 1'b0;
    t = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      t++;
      if (i == 0) check("go_pulse", 64'({bus.fu_go, bus.gnt_o}), 64'd0);
      if (side && i == 1) begin
        bus.req_i[exp_gnt[0]] = 1'b1;
        bus.n_i = {4'd9, 4'd9};
      end
      if (side && i == 3) bus.req_i[exp_gnt[0]] = 1'b0;
      got = (bus.done_o != 2'b00);
    end
    check("done_seen", 64'(got), 64'd1);
    if (!got) return;
    check("done", 64'(bus.done_o), 64'(exp_gnt));
    check("result", 64'(bus.result_o), 64'(exp_res));
    check("err", 64'(bus.err_o), 64'(exp_err));
    check("latency", 64'(t), 64'(lat + 2));
    check("abort_idle", 64'(bus.fu_abort), 64'd0);
    check("fu_n_hold", 64'(bus.fu_n), 64'(n_win));
    m_ptr    = ~m_ptr;
    last_res = exp_res;
    last_err = exp_err;
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [3:0]  n0;
    logic [3:0]  n1;
    logic [1:0]  gnt;
    logic [31:0] res;
    logic        err;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [1:0] lo;
    int         cnt;
    logic       got;
    tbl[0] = '{2'b01, 4'd3,  4'd0,  2'b01, 32'd6,          1'b0};
    tbl[1] = '{2'b10, 4'd0,  4'd5,  2'b10, 32'd120,        1'b0};
    tbl[2] = '{2'b11, 4'd3,  4'd4,  2'b01, 32'd6,          1'b0};
    tbl[3] = '{2'b11, 4'd3,  4'd4,  2'b10, 32'd24,         1'b0};
    tbl[4] = '{2'b11, 4'd7,  4'd2,  2'b01, 32'd5040,       1'b0};
    tbl[5] = '{2'b11, 4'd7,  4'd2,  2'b10, 32'd2,          1'b0};
    tbl[6] = '{2'b01, 4'd13, 4'd0,  2'b01, 32'd1932053504, 1'b1};
    tbl[7] = '{2'b10, 4'd0,  4'd0,  2'b10, 32'd1,          1'b0};
    tbl[8] = '{2'b01, 4'd12, 4'd0,  2'b01, 32'd479001600,  1'b0};
    tbl[9] = '{2'b10, 4'd0,  4'd15, 2'b10, 32'd2004310016, 1'b1};

    bus.req_i = 2'b00;
    bus.n_i   = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_gnt", 64'(bus.gnt_o), 64'd0);
    check("rst_done", 64'(bus.done_o), 64'd0);
    check("rst_result", 64'(bus.result_o), 64'd0);
    check("rst_err", 64'(bus.err_o), 64'd0);
    check("rst_go", 64'(bus.fu_go), 64'd0);
    check("rst_fu_n", 64'(bus.fu_n), 64'd0);
    check("rst_abort", 64'(bus.fu_abort), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 10; k++)
      run_job(tbl[k].req, tbl[k].n0, tbl[k].n1, tbl[k].gnt, tbl[k].res, tbl[k].err,
              (k % 4) + 1, 1'b0);

    // Randomized jobs; a loser keeps requesting into the next round.
    lo = 2'b00;
    m_n[0] = 4'd0;
    m_n[1] = 4'd0;
    for (int k = 0; k < 40; k++) begin
      logic [1:0] pat;
      logic [1:0] nreq;
      logic [1:0] eg;
      logic       w;
      pat  = 2'($urandom_range(1, 3));
      nreq = lo | pat;
      if (pat[0] && !lo[0]) m_n[0] = 4'($urandom_range(0, 15));
      if (pat[1] && !lo[1]) m_n[1] = 4'($urandom_range(0, 15));
      w  = (nreq == 2'b11) ? m_ptr : nreq[1];
      eg = w ? 2'b10 : 2'b01;
      run_job(nreq, m_n[0], m_n[1], eg, ref_fact(int'(m_n[w])), (m_n[w] > 4'd12),
              int'($urandom_range(1, 5)), 1'b0);
      lo = nreq & ~eg;
    end
    bus.req_i = 2'b00;

    // fu_done while idle must be ignored.
    man_res = 32'hDEAD_BEEF;
    @(negedge clk);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done_o != 2'b00 || bus.gnt_o != 2'b00) cnt++;
    end
    check("stray_done", 64'(cnt), 64'd0);
    check("result_hold", 64'(bus.result_o), 64'(last_res));
    check("err_hold", 64'(bus.err_o), 64'(last_err));

    // A request raised and withdrawn while busy is never granted.
    run_job(2'b01, 4'd4, 4'd0, 2'b01, 32'd24, 1'b0, 6, 1'b1);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.gnt_o != 2'b00) cnt++;
    end
    check("withdrawn_gnt", 64'(cnt), 64'd0);

`ifdef FACT_ARB_TIMEOUT_EN
    // Unit never completes: abort TIMEOUT cycles after fu_go.
    stub_en = 1'b0;
    bus.req_i = 2'b01;
    bus.n_i = 8'h05;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = bus.fu_go;
    end
    bus.req_i = 2'b00;
    cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      cnt++;
      got = bus.fu_abort;
    end
    check("abort_seen", 64'(got), 64'd1);
    check("abort_delay", 64'(cnt), 64'(TIMEOUT));
    check("to_done", 64'(bus.done_o), 64'd1);
    check("to_err", 64'(bus.err_o), 64'd1);
    check("to_result", 64'(bus.result_o), 64'd0);
    m_ptr = ~m_ptr;
    stub_en = 1'b1;
    @(negedge clk);
`endif

    // Reset during WAIT with the pointer at requester 1.
    if (m_ptr == 1'b0) run_job(2'b01, 4'd2, 4'd0, 2'b01, 32'd2, 1'b0, 1, 1'b0);
    stub_lat = 10;
    bus.req_i = 2'b01;
    bus.n_i = 8'h06;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = (bus.gnt_o != 2'b00);
    end
    bus.req_i = 2'b00;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_gnt", 64'(bus.gnt_o), 64'd0);
    check("mid_done", 64'(bus.done_o), 64'd0);
    check("mid_result", 64'(bus.result_o), 64'd0);
    check("mid_err", 64'(bus.err_o), 64'd0);
    check("mid_go", 64'(bus.fu_go), 64'd0);
    check("mid_fu_n", 64'(bus.fu_n), 64'd0);
    check("mid_abort", 64'(bus.fu_abort), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 1'b0;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done_o != 2'b00) cnt++;
    end
    check("post_rst_done", 64'(cnt), 64'd0);
    run_job(2'b11, 4'd3, 4'd4, 2'b01, 32'd6, 1'b0, 2, 1'b0);
    bus.req_i = 2'b00;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d of %0d checks bad", n_err, n_vec);
    $fatal(1, "watchdog");
  end

endmodule
